cdb_arbiter: RTL

Arbitrates completing functional-unit results onto the 6-lane common data bus that feeds the ROB complete port (`cdb_pr_ready`, `cdb_pr_tag_0..5`) and the other CDB consumers. Up to 8 requesters compete each cycle. A rotating-priority pointer grants up to 6 of them, packs the winners into lanes 0..5 in priority order, and registers the lanes so the CDB is driven one cycle after grant. Losing requesters hold their request until granted. The pointer bounds the wait for any requester to 2 cycles.

---
 rtl/cdb_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Rotating-priority arbiter for the common data bus. Up to NUM_REQ functional
// units present completed results each cycle; up to NUM_LANES of them are
// granted, packed in priority order into lanes 0..NUM_LANES-1 and driven onto
// the CDB from registers one cycle after the grant.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high
//   fu_req        per-FU request (result available)
//   fu_tag        per-FU physical register tag, FU i in [i*TAG_W +: TAG_W]
//   squash        pipeline flush: no grants this cycle, bus cleared next edge
//   fu_grant      combinational per-FU accept
//   cdb_pr_ready  registered lane valid bits
//   cdb_pr_tag    registered lane tags, lane k in [k*TAG_W +: TAG_W]
//   rr_ptr        index of the current highest-priority requester
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int NUM_LANES = 6,
    parameter int TAG_W     = 7
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             fu_req,
    input  logic [NUM_REQ*TAG_W-1:0]       fu_tag,
    input  logic                           squash,
    output logic [NUM_REQ-1:0]             fu_grant,
    output logic [NUM_LANES-1:0]           cdb_pr_ready,
    output logic [NUM_LANES*TAG_W-1:0]     cdb_pr_tag,
    output logic [$clog2(NUM_REQ)-1:0]     rr_ptr
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(NUM_LANES + 1);
    localparam int OFF_W = PTR_W + 1;

    // Typed copies of the parameters so comparisons stay width-matched.
    localparam logic [PTR_W+1:0] REQ_L   = (PTR_W + 2)'(NUM_REQ);
    localparam logic [CNT_W-1:0] LANES_L = CNT_W'(NUM_LANES);
    localparam logic [TAG_W-1:0] NO_TAG  = '1;

    // base + off modulo NUM_REQ. Both operands are below NUM_REQ (off may
    // equal NUM_REQ when stepping past the last requester), so one
    // conditional subtraction is enough.
    function automatic logic [PTR_W-1:0] wrap_add(
        input logic [PTR_W-1:0] base,
        input logic [OFF_W-1:0] off
    );
        logic [PTR_W+1:0] sum;
        sum = {2'b00, base} + {1'b0, off};
        if (sum >= REQ_L) begin
            sum = sum - REQ_L;
        end
        return sum[PTR_W-1:0];
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0]     rr_ptr_reg;
    logic [PTR_W-1:0]     rr_ptr_next;
    logic [NUM_LANES-1:0] ready_reg;
    logic [TAG_W-1:0]     tag_reg  [NUM_LANES];

    // -----------------------------------------------------------------------
    // Per-FU tag view
    // -----------------------------------------------------------------------
    logic [TAG_W-1:0] tag_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_tag_split
            assign tag_arr[gi] = fu_tag[gi*TAG_W +: TAG_W];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Priority scan
    //
    // Walk the requesters starting at rr_ptr. Each requester found while lane
    // capacity remains is granted and dropped into the next free lane, so
    // lane order matches priority order. The offset of the last grant drives
    // the pointer update, which makes every loser of this cycle a winner-first
    // candidate next cycle and bounds any wait to two cycles.
    // -----------------------------------------------------------------------
    logic [NUM_REQ-1:0]   grant_vec;
    logic [NUM_LANES-1:0] lane_valid;
    logic [TAG_W-1:0]     lane_tag [NUM_LANES];
    logic [CNT_W-1:0]     cnt;
    logic [OFF_W-1:0]     last_off;
    logic                 any_grant;
    logic [PTR_W-1:0]     idx;
    logic                 blocked;

    // Reset and squash both suppress all grants; with nothing granted the
    // lanes default to empty, which is exactly the cleared bus state.
    assign blocked = reset | squash;

    always_comb begin
        grant_vec  = '0;
        lane_valid = '0;
        cnt        = '0;
        last_off   = '0;
        any_grant  = 1'b0;
        idx        = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            lane_tag[j] = NO_TAG;
        end

        if (!blocked) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = wrap_add(rr_ptr_reg, OFF_W'(k));
                if (fu_req[idx] && (cnt < LANES_L)) begin
                    grant_vec[idx]  = 1'b1;
                    lane_valid[cnt] = 1'b1;
                    lane_tag[cnt]   = tag_arr[idx];
                    cnt             = cnt + 1'b1;
                    last_off        = OFF_W'(k);
                    any_grant       = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past the last granted requester; idle cycles keep it.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (any_grant) begin
            rr_ptr_next = wrap_add(rr_ptr_reg, last_off + 1'b1);
        end
    end

    // -----------------------------------------------------------------------
    // Registered bus and pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            always_ff @(posedge clock) begin
                if (reset) begin
                    ready_reg[gi] <= 1'b0;
                    tag_reg[gi]   <= NO_TAG;
                end else begin
                    ready_reg[gi] <= lane_valid[gi];
                    tag_reg[gi]   <= lane_tag[gi];
                end
            end
            assign cdb_pr_tag[gi*TAG_W +: TAG_W] = tag_reg[gi];
        end
    endgenerate

    assign fu_grant     = grant_vec;
    assign cdb_pr_ready = ready_reg;
    assign rr_ptr       = rr_ptr_reg;

endmodule
